// File: rtl/rst_seq_ctrl.sv
// Staggered reset sequencer: one POR in, NumDomains synchronously released domain resets out.
// Optional build macro RST_SEQ_CAUSE_EN adds a registered reset-cause output.

module rst_seq_dom (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic set_i,
  input  logic clr_i,
  input  logic scan_en_i,
  input  logic scan_rst_ni,
  output logic rst_no
);
  logic rel_q;

  // Clear has priority so a SW request always re-asserts the domain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    rel_q <= 1'b0;
    else if (clr_i) rel_q <= 1'b0;
    else if (set_i) rel_q <= 1'b1;
  end

  assign rst_no = scan_en_i ? scan_rst_ni : rel_q;
endmodule

module rst_seq_ctrl #(
  parameter int NumDomains    = 4,
  parameter int HoldCycles    = 8,
  parameter int StaggerCycles = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [3:0]            scanmode_i,
  input  logic                  scan_rst_ni,
  input  logic                  sw_rst_req_i,
  output logic                  sw_rst_ack_o,
  output logic [NumDomains-1:0] rst_domain_no,
  output logic                  seq_done_o,
  output logic [1:0]            state_o
`ifdef RST_SEQ_CAUSE_EN
  ,
  output logic [1:0]            cause_o
`endif
);
  localparam int MaxCyc = (HoldCycles > StaggerCycles) ? HoldCycles : StaggerCycles;
  localparam int CntW   = $clog2(MaxCyc + 1);
  localparam int IdxW   = $clog2(NumDomains + 1);
  localparam logic [3:0] LcTxOn = 4'b0101;

  typedef enum logic [1:0] {
    StHold    = 2'd0,
    StRelease = 2'd1,
    StDone    = 2'd2
  } state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [IdxW-1:0]   idx_q;
  logic              req_q;
  logic              seq_done_q;
  logic              ack_q;
  logic              sw_seq_q;
  logic              hold_fire;
  logic              rel_fire;
  logic              all_rel;
  logic              sw_edge;
  logic              dom_clr;
  logic              scan_en;
  logic [NumDomains-1:0] dom_set;

  assign sw_edge   = sw_rst_req_i & ~req_q;
  assign all_rel   = (idx_q == IdxW'(NumDomains));
  assign hold_fire = (state_q == StHold) && (idx_q == '0) && (cnt_q == CntW'(HoldCycles - 1));
  assign rel_fire  = (state_q == StRelease) && !all_rel && (cnt_q == CntW'(StaggerCycles - 1));
  assign dom_clr   = (state_q == StDone) && sw_edge;
  assign scan_en   = (scanmode_i == LcTxOn);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StHold;
      cnt_q      <= '0;
      idx_q      <= '0;
      req_q      <= 1'b0;
      seq_done_q <= 1'b0;
      ack_q      <= 1'b0;
      sw_seq_q   <= 1'b0;
    end else begin
      req_q <= sw_rst_req_i;
      ack_q <= 1'b0;
      unique case (state_q)
        StHold: begin
          // A single domain is released from HOLD; DONE follows one edge later.
          if (all_rel) begin
            state_q    <= StDone;
            cnt_q      <= '0;
            seq_done_q <= 1'b1;
            ack_q      <= sw_seq_q;
          end else if (hold_fire) begin
            idx_q   <= IdxW'(1);
            cnt_q   <= '0;
            state_q <= (NumDomains > 1) ? StRelease : StHold;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StRelease: begin
          if (all_rel) begin
            state_q    <= StDone;
            cnt_q      <= '0;
            seq_done_q <= 1'b1;
            ack_q      <= sw_seq_q;
          end else if (rel_fire) begin
            idx_q <= idx_q + IdxW'(1);
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          if (sw_edge) begin
            state_q    <= StHold;
            cnt_q      <= '0;
            idx_q      <= '0;
            seq_done_q <= 1'b0;
            sw_seq_q   <= 1'b1;
          end
        end
        default: state_q <= StHold;
      endcase
    end
  end

`ifdef RST_SEQ_CAUSE_EN
  logic [1:0] cause_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      cause_q <= 2'b01;
    else if (dom_clr) cause_q <= 2'b10;
  end
  assign cause_o = cause_q;
`endif

  for (genvar k = 0; k < NumDomains; k++) begin : g_dom
    assign dom_set[k] = ((k == 0) && hold_fire) || (rel_fire && (idx_q == IdxW'(k)));
    rst_seq_dom u_dom (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .set_i       (dom_set[k]),
      .clr_i       (dom_clr),
      .scan_en_i   (scan_en),
      .scan_rst_ni (scan_rst_ni),
      .rst_no      (rst_domain_no[k])
    );
  end

  assign seq_done_o   = seq_done_q;
  assign sw_rst_ack_o = ack_q;
  assign state_o      = state_q;
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: default 4-domain instance plus a 1-domain, 1-hold instance.
module tb_rst_seq_ctrl;
  localparam logic [3:0] ON  = 4'b0101;
  localparam logic [3:0] OFF = 4'b1010;
  localparam int H = 0, R = 1, D = 2, X = -1;

  logic       clk = 1'b0;
  logic       rst_a = 1'b0, rst_b = 1'b0;
  logic [3:0] scan_a = OFF, scan_b = OFF;
  logic       srst_a = 1'b0, srst_b = 1'b0;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic       ack_a, ack_b, done_a, done_b;
  logic [3:0] dom_a;
  logic [0:0] dom_b;
  logic [1:0] st_a, st_b;
  logic [1:0] cause_a, cause_b;
  int         cyc = 0;
  int         checks = 0, errors = 0;

  typedef struct {
    int         cyc;
    int         dut;
    logic [3:0] dom;
    logic       done;
    int         st;
    logic [1:0] cause;
  } exp_t;

  exp_t expq[$];
  int   ackq_a[$], ackq_b[$];
  exp_t e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rst_seq_ctrl u_a (
    .clk_i(clk), .rst_ni(rst_a), .scanmode_i(scan_a), .scan_rst_ni(srst_a),
    .sw_rst_req_i(req_a), .sw_rst_ack_o(ack_a), .rst_domain_no(dom_a),
    .seq_done_o(done_a), .state_o(st_a)
`ifdef RST_SEQ_CAUSE_EN
    , .cause_o(cause_a)
`endif
  );

  rst_seq_ctrl #(.NumDomains(1), .HoldCycles(1), .StaggerCycles(2)) u_b (
    .clk_i(clk), .rst_ni(rst_b), .scanmode_i(scan_b), .scan_rst_ni(srst_b),
    .sw_rst_req_i(req_b), .sw_rst_ack_o(ack_b), .rst_domain_no(dom_b),
    .seq_done_o(done_b), .state_o(st_b)
`ifdef RST_SEQ_CAUSE_EN
    , .cause_o(cause_b)
`endif
  );

`ifndef RST_SEQ_CAUSE_EN
  assign cause_a = 2'b00;
  assign cause_b = 2'b00;
`endif

  task automatic chk(input string name, input int c, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, c, act, exp);
    end
  endtask

  task automatic push(input int c, input int d, input logic [3:0] dom, input logic done,
                      input int st, input logic [1:0] cause);
    exp_t x;
    x.cyc = c; x.dut = d; x.dom = dom; x.done = done; x.st = st; x.cause = cause;
    expq.push_back(x);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: compares queued expectations and all ack pulses at each falling edge.
  always @(negedge clk) begin
    while (expq.size() > 0 && expq[0].cyc < cyc) begin
      e = expq.pop_front();
      chk("missed_expectation", e.cyc, 1, 0);
    end
    while (expq.size() > 0 && expq[0].cyc == cyc) begin
      e = expq.pop_front();
      if (e.dut == 0) begin
        chk("a_dom", cyc, int'(dom_a), int'(e.dom));
        chk("a_done", cyc, int'(done_a), int'(e.done));
        if (e.st >= 0) chk("a_state", cyc, int'(st_a), e.st);
`ifdef RST_SEQ_CAUSE_EN
        chk("a_cause", cyc, int'(cause_a), int'(e.cause));
`endif
      end else begin
        chk("b_dom", cyc, int'(dom_b), int'(e.dom));
        chk("b_done", cyc, int'(done_b), int'(e.done));
        if (e.st >= 0) chk("b_state", cyc, int'(st_b), e.st);
`ifdef RST_SEQ_CAUSE_EN
        chk("b_cause", cyc, int'(cause_b), int'(e.cause));
`endif
      end
    end
    if (ack_a) begin
      if (ackq_a.size() > 0 && ackq_a[0] == cyc) begin
        checks++;
        void'(ackq_a.pop_front());
      end else chk("a_ack_spurious", cyc, 1, 0);
    end
    while (ackq_a.size() > 0 && ackq_a[0] < cyc) chk("a_ack_missing", ackq_a.pop_front(), 0, 1);
    if (ack_b) begin
      if (ackq_b.size() > 0 && ackq_b[0] == cyc) begin
        checks++;
        void'(ackq_b.pop_front());
      end else chk("b_ack_spurious", cyc, 1, 0);
    end
    while (ackq_b.size() > 0 && ackq_b[0] < cyc) chk("b_ack_missing", ackq_b.pop_front(), 0, 1);
  end

  initial begin
    int b, ev, c, b2, b3, bb, eb;
    push(2, 0, 4'b0000, 1'b0, H, 2'b01);
    push(2, 1, 4'b0000, 1'b0, H, 2'b01);
    wait_cyc(3);

    // POR sequence, with a request pulse at edge 11 that must be ignored
    rst_a = 1'b1; b = cyc;
    push(b+1,  0, 4'b0000, 0, H, 2'b01);
    push(b+7,  0, 4'b0000, 0, H, 2'b01);
    push(b+8,  0, 4'b0001, 0, R, 2'b01);
    push(b+9,  0, 4'b0001, 0, R, 2'b01);
    push(b+10, 0, 4'b0011, 0, R, 2'b01);
    push(b+11, 0, 4'b0011, 0, R, 2'b01);
    push(b+12, 0, 4'b0111, 0, R, 2'b01);
    push(b+14, 0, 4'b1111, 0, R, 2'b01);
    push(b+15, 0, 4'b1111, 1, D, 2'b01);
    push(b+16, 0, 4'b1111, 1, D, 2'b01);
    wait_cyc(b+10); req_a = 1'b1;
    wait_cyc(b+11); req_a = 1'b0;

    // SW request at edge ev, held high long after completion
    ev = b + 20;
    push(ev,    0, 4'b0000, 0, H, 2'b10);
    push(ev+7,  0, 4'b0000, 0, H, 2'b10);
    push(ev+8,  0, 4'b0001, 0, R, 2'b10);
    push(ev+10, 0, 4'b0011, 0, R, 2'b10);
    push(ev+12, 0, 4'b0111, 0, R, 2'b10);
    push(ev+14, 0, 4'b1111, 0, R, 2'b10);
    push(ev+15, 0, 4'b1111, 1, D, 2'b10);
    push(ev+30, 0, 4'b1111, 1, D, 2'b10);
    ackq_a.push_back(ev+15);
    wait_cyc(ev-1); req_a = 1'b1;
    wait_cyc(ev+30); req_a = 1'b0;

    // Scan bypass in DONE, then async POR from DONE
    c = cyc;
    push(c+1, 0, 4'b0000, 1, D, 2'b10);
    push(c+2, 0, 4'b1111, 1, D, 2'b10);
    push(c+3, 0, 4'b1111, 1, D, 2'b10);
    push(c+5, 0, 4'b0000, 0, H, 2'b01);
    @(posedge clk); #1 scan_a = ON;      srst_a = 1'b0;
    @(posedge clk); #1 srst_a = 1'b1;
    @(posedge clk); #1 scan_a = 4'b1111; srst_a = 1'b0;
    @(posedge clk); #1 scan_a = OFF;
    @(posedge clk); #1 rst_a = 1'b0;
    wait_cyc(c+6);

    // Restart, then async POR at edge 11
    rst_a = 1'b1; b2 = cyc;
    push(b2+1,  0, 4'b0000, 0, H, 2'b01);
    push(b2+8,  0, 4'b0001, 0, R, 2'b01);
    push(b2+10, 0, 4'b0011, 0, R, 2'b01);
    push(b2+11, 0, 4'b0000, 0, H, 2'b01);
    wait_cyc(b2+10);
    @(posedge clk); #1 rst_a = 1'b0;
    wait_cyc(b2+12);

    // Full restart with a one-cycle scan override that must not disturb the FSM
    rst_a = 1'b1; b3 = cyc;
    push(b3+1,  0, 4'b0000, 0, H, 2'b01);
    push(b3+8,  0, 4'b0001, 0, R, 2'b01);
    push(b3+9,  0, 4'b1111, 0, R, 2'b01);
    push(b3+10, 0, 4'b0011, 0, R, 2'b01);
    push(b3+14, 0, 4'b1111, 0, R, 2'b01);
    push(b3+15, 0, 4'b1111, 1, D, 2'b01);
    wait_cyc(b3+8);
    @(posedge clk); #1 scan_a = ON; srst_a = 1'b1;
    @(posedge clk); #1 scan_a = OFF;
    wait_cyc(b3+17);

    // Single-domain instance: POR then SW sequence
    rst_b = 1'b1; bb = cyc;
    push(bb+1, 1, 4'b0001, 0, X, 2'b01);
    push(bb+2, 1, 4'b0001, 1, D, 2'b01);
    push(bb+4, 1, 4'b0001, 1, D, 2'b01);
    eb = bb + 5;
    push(eb,   1, 4'b0000, 0, H, 2'b10);
    push(eb+1, 1, 4'b0001, 0, X, 2'b10);
    push(eb+2, 1, 4'b0001, 1, D, 2'b10);
    push(eb+4, 1, 4'b0001, 1, D, 2'b10);
    ackq_b.push_back(eb+2);
    wait_cyc(eb-1); req_b = 1'b1;
    wait_cyc(eb+4); req_b = 1'b0;
    wait_cyc(eb+6);

    chk("exp_queue_drained", cyc, expq.size(), 0);
    chk("ack_queues_drained", cyc, ackq_a.size() + ackq_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
- Parametrised reset sequencer that turns one asynchronous power-on reset into NumDomains staggered, synchronously released domain resets.
- Sits between the top-level por_n_i and the per-domain reset inputs of the RoT subsystems.
- Adds a configurable hold time, staggered per-domain release, a software reset request/ack handshake, and a scan-mode bypass driven by scan_rst_ni.

Parameters:
- NumDomains, 4, number of reset domains released in order 0..NumDomains-1; must be >= 1.
- HoldCycles, 8, cycles all domains stay in reset after rst_ni deasserts or after a SW request; must be >= 1.
- StaggerCycles, 2, cycles between the release of domain k and domain k+1; must be >= 1.

Ports:
- clk_i  input  1  sequencer clock.
- rst_ni  input  1  asynchronous active-low reset (POR).
- scanmode_i  input  4  lc_ctrl_pkg::lc_tx_t; only the value lc_ctrl_pkg::On selects scan bypass.
- scan_rst_ni  input  1  scan reset; drives all domain resets in bypass.
- sw_rst_req_i  input  1  software reset request (level, rising-edge detected).
- sw_rst_ack_o  output  1  one-cycle pulse when a SW-initiated sequence completes.
- rst_domain_no  output  NumDomains  per-domain active-low resets.
- seq_done_o  output  1  all domains released.
- state_o  output  2  FSM state: HOLD=0, RELEASE=1, DONE=2.

Behaviour:
- Async reset (rst_ni=0), all outputs: rst_domain_no=all 0, seq_done_o=0, sw_rst_ack_o=0, state_o=HOLD, counter=0, domain index=0, req edge register=0.
- Counter width is $clog2(max(HoldCycles,StaggerCycles)+1). The counter never wraps; it is cleared on every state transition.
- HOLD: the counter increments each edge. At edge HoldCycles (first edge after rst_ni release = edge 1), rst_domain_no[0]<=1, FSM goes to RELEASE, counter<=0, idx<=1.
- RELEASE: the counter increments. When it reaches StaggerCycles-1, rst_domain_no[idx]<=1 and idx increments. Domain k is therefore released at edge HoldCycles+k*StaggerCycles.
- RELEASE exit: one edge after the last domain is released, FSM goes to DONE and seq_done_o<=1.
- NumDomains=1: the FSM goes straight from HOLD to DONE on the next edge.
- Release is monotonic: a released domain is never re-asserted except by a SW request or by rst_ni.
- DONE: a rising edge on sw_rst_req_i (sampled req=1, previous=0) at edge e sets rst_domain_no=0, seq_done_o=0, FSM to HOLD, counter<=0. Release then repeats relative to e.
- Rising edges of sw_rst_req_i seen in HOLD or RELEASE are ignored, not queued. The edge register still updates every cycle.
- sw_rst_ack_o is high for exactly one cycle, on the edge the FSM enters DONE, and only if the current sequence was SW-initiated. It is never high after a POR-only sequence.
- Scan bypass: when scanmode_i==lc_ctrl_pkg::On, rst_domain_no = {NumDomains{scan_rst_ni}} combinationally. The FSM keeps running, unaffected. Any other scanmode_i value (including invalid encodings) selects the FSM outputs.
- rst_ni asserted mid-sequence: outputs return immediately and asynchronously to reset values.
- All non-bypass outputs are registered.

Optional Feature:
- Macro: RST_SEQ_CAUSE_EN.
- Defined: adds output cause_o (2 bits, registered). Reset value 2'b01 (POR). Set to 2'b10 (SW) on SW-request acceptance. Held until the next rst_ni or SW request. Value 2'b00 is never produced.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Defaults, release rst_ni before edge 1 -> rst_domain_no=4'b0001 at edge 8, 4'b0011 at 10, 4'b0111 at 12, 4'b1111 at 14; seq_done_o=1 at edge 15; sw_rst_ack_o stays 0.
- In DONE, raise sw_rst_req_i at edge e and hold it high -> rst_domain_no=0, state_o=0 at e. Domains release at e+8/10/12/14. sw_rst_ack_o is a single pulse at e+15. No second sequence starts while req stays high.
- Pulse sw_rst_req_i during RELEASE (edge 11) -> ignored; sequence finishes at edge 15 with no ack.
- scanmode_i=lc_ctrl_pkg::On, toggle scan_rst_ni 0/1 -> rst_domain_no follows 4'b0000/4'b1111 in the same cycle. scanmode_i=lc_ctrl_pkg::Off -> FSM values return.
- Assert rst_ni at edge 11 -> rst_domain_no=0, seq_done_o=0 asynchronously. After release, the full sequence restarts from edge 1.
- NumDomains=1, HoldCycles=1 (plus RST_SEQ_CAUSE_EN) -> domain released at edge 1, seq_done_o at edge 2, cause_o=2'b01. After a SW request, cause_o=2'b10.
